// File: rtl/vm2002_stock_arbiter_if.sv
// vm2002_stock_arbiter_if: restock/purchase handshakes plus busy and empty_map; slave = arbiter side, master = requester side
interface vm2002_stock_arbiter_if #(
  parameter int NUM_ITEMS = 7,
  parameter int CNT_W     = 5,
  parameter int COST_W    = 16
);
  logic                 rs_req;
  logic [2:0]           rs_item;
  logic [CNT_W-1:0]     rs_count;
  logic [COST_W-1:0]    rs_cost;
  logic                 rs_done;
  logic                 rs_err;
  logic                 pu_req;
  logic                 pu_op;
  logic [2:0]           pu_item;
  logic                 pu_done;
  logic                 pu_avail;
  logic [COST_W-1:0]    pu_cost;
  logic                 pu_err;
  logic                 busy;
  logic [NUM_ITEMS-1:0] empty_map;
  modport slave (
    input  rs_req, rs_item, rs_count, rs_cost, pu_req, pu_op, pu_item,
    output rs_done, rs_err, pu_done, pu_avail, pu_cost, pu_err, busy, empty_map
  );
  modport master (
    output rs_req, rs_item, rs_count, rs_cost, pu_req, pu_op, pu_item,
    input  rs_done, rs_err, pu_done, pu_avail, pu_cost, pu_err, busy, empty_map
  );
endinterface

// File: rtl/vm2002_stock_arbiter.sv
// vm2002_stock_arbiter: stock/cost table arbitrated between restock and purchase ports (clk, hrst async, bus slave); VM2002_RR_ARB_EN selects round-robin
module vm2002_stock_arbiter #(
  parameter int                NUM_ITEMS    = 7,
  parameter int                CNT_W        = 5,
  parameter int                MAX_COUNT    = 16,
  parameter int                COST_W       = 16,
  parameter logic [COST_W-1:0] DEFAULT_COST = 16'h0
) (
  input  logic                  clk,
  input  logic                  hrst,
  vm2002_stock_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, UPDATE, DONE} state_t;
  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt [NUM_ITEMS];
  logic [COST_W-1:0]   r_cost [NUM_ITEMS];
  logic                r_pu_win, r_op, r_rs_err, r_pu_avail, r_pu_err;
  logic [2:0]          r_item;
  logic [CNT_W-1:0]    r_add, r_rd_cnt;
  logic [COST_W-1:0]   r_new_cost, r_rd_cost, r_pu_cost;
  logic                w_pu_win, w_valid, w_ovf, w_nz, w_req;
  logic [2:0]          w_item;
  logic [CNT_W:0]      w_sum;
  assign w_req   = bus.pu_req | bus.rs_req;
`ifdef VM2002_RR_ARB_EN
  logic r_last_pu;
  assign w_pu_win = bus.pu_req & (~bus.rs_req | ~r_last_pu);
  always_ff @(posedge clk or posedge hrst)
    if (hrst) r_last_pu <= 1'b0;
    else if (r_state == IDLE && w_req) r_last_pu <= w_pu_win;
`else
  assign w_pu_win = bus.pu_req;
`endif
  assign w_item  = r_pu_win ? bus.pu_item : bus.rs_item;
  assign w_valid = 32'(r_item) < NUM_ITEMS;
  assign w_sum   = {1'b0, r_rd_cnt} + {1'b0, r_add};
  assign w_ovf   = w_sum > (CNT_W+1)'(MAX_COUNT);
  assign w_nz    = r_rd_cnt != '0;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE   ? (w_req ? ACCESS : IDLE) :
             r_state == ACCESS ? UPDATE :
             r_state == UPDATE ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge hrst)
    if (hrst) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk or posedge hrst)
    if (hrst) begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        r_cnt[k]  <= '0;
        r_cost[k] <= DEFAULT_COST;
      end
      r_pu_win   <= 1'b0;
      r_op       <= 1'b0;
      r_item     <= '0;
      r_add      <= '0;
      r_new_cost <= '0;
      r_rd_cnt   <= '0;
      r_rd_cost  <= '0;
      r_rs_err   <= 1'b0;
      r_pu_avail <= 1'b0;
      r_pu_err   <= 1'b0;
      r_pu_cost  <= '0;
    end else begin
      if (r_state == IDLE) r_pu_win <= w_pu_win;
      if (r_state == ACCESS) begin
        r_item     <= w_item;
        r_op       <= bus.pu_op;
        r_add      <= bus.rs_count;
        r_new_cost <= bus.rs_cost;
        r_rd_cnt   <= 32'(w_item) < NUM_ITEMS ? r_cnt[w_item] : '0;
        r_rd_cost  <= 32'(w_item) < NUM_ITEMS ? r_cost[w_item] : '0;
      end
      if (r_state == UPDATE) begin
        if (r_pu_win) begin
          r_pu_avail <= w_valid & w_nz;
          r_pu_err   <= ~w_valid | (r_op & ~w_nz);
          r_pu_cost  <= w_valid ? r_rd_cost : '0;
          if (w_valid & r_op & w_nz) r_cnt[r_item] <= r_rd_cnt - CNT_W'(1);
        end else begin
          r_rs_err <= ~w_valid | w_ovf;
          if (w_valid & ~w_ovf) r_cnt[r_item] <= w_sum[CNT_W-1:0];
          if (w_valid & (r_new_cost != '0)) r_cost[r_item] <= r_new_cost;
        end
      end
    end
  assign bus.rs_done  = (r_state == DONE) & ~r_pu_win;
  assign bus.pu_done  = (r_state == DONE) & r_pu_win;
  assign bus.busy     = r_state != IDLE;
  assign bus.rs_err   = r_rs_err;
  assign bus.pu_avail = r_pu_avail;
  assign bus.pu_err   = r_pu_err;
  assign bus.pu_cost  = r_pu_cost;
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_map
    assign bus.empty_map[i] = r_cnt[i] == '0;
  end
endmodule

// File: tb/tb_vm2002_stock_arbiter.sv
// tb_vm2002_stock_arbiter: randomized and directed checks of the stock arbiter against a table model
module tb_vm2002_stock_arbiter;
`ifdef VM2002_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic hrst = 1'b1;
  int n_total = 0;
  int n_bad = 0;
  logic [4:0]  m_cnt [7];
  logic [15:0] m_cost [7];
  logic        m_rs_err, m_pu_avail, m_pu_err, m_last_pu;
  logic [15:0] m_pu_cost;
  vm2002_stock_arbiter_if bus();
  vm2002_stock_arbiter dut (.clk(clk), .hrst(hrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] m_map();
    for (int i = 0; i < 7; i++) m_map[i] = m_cnt[i] == 0;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 7; i++) begin
      m_cnt[i]  = 0;
      m_cost[i] = 16'h0;
    end
    m_rs_err = 0; m_pu_avail = 0; m_pu_err = 0; m_pu_cost = 0; m_last_pu = 0;
  endtask
  task automatic m_rs(input logic [2:0] it, input logic [4:0] c, input logic [15:0] co);
    int s;
    if (it >= 7) m_rs_err = 1;
    else begin
      s = int'(m_cnt[it]) + int'(c);
      m_rs_err = s > 16;
      if (s <= 16) m_cnt[it] = 5'(s);
      if (co != 0) m_cost[it] = co;
    end
  endtask
  task automatic m_pu(input logic op, input logic [2:0] it);
    if (it >= 7) begin
      m_pu_avail = 0; m_pu_err = 1; m_pu_cost = 0;
    end else begin
      m_pu_avail = m_cnt[it] != 0;
      m_pu_cost  = m_cost[it];
      m_pu_err   = op && m_cnt[it] == 0;
      if (op && m_cnt[it] != 0) m_cnt[it] = m_cnt[it] - 1;
    end
  endtask
  task automatic chk_outs(input string tag);
    chk({tag, "_rs_err"}, bus.rs_err, m_rs_err);
    chk({tag, "_pu_res"}, {bus.pu_avail, bus.pu_err, bus.pu_cost}, {m_pu_avail, m_pu_err, m_pu_cost});
    chk({tag, "_map"}, bus.empty_map, m_map());
  endtask
  task automatic txn(input bit do_rs, input logic [2:0] ri, input logic [4:0] rc, input logic [15:0] rco,
                     input bit do_pu, input logic po, input logic [2:0] pi);
    int n, tp, tr;
    bit w_pu;
    w_pu = do_pu && (!do_rs || !RR || !m_last_pu);
    @(posedge clk); #1;
    bus.rs_req = do_rs; bus.rs_item = ri; bus.rs_count = rc; bus.rs_cost = rco;
    bus.pu_req = do_pu; bus.pu_op = po; bus.pu_item = pi;
    tp = -1; tr = -1; n = 0;
    while (((do_pu && tp < 0) || (do_rs && tr < 0)) && n < 20) begin
      @(negedge clk);
      if (n == 1) chk("busy", bus.busy, 1);
      if (bus.pu_done) begin
        chk("pu_done_req", bus.pu_done, do_pu);
        tp = n; m_pu(po, pi); chk_outs("pu");
      end
      if (bus.rs_done) begin
        chk("rs_done_req", bus.rs_done, do_rs);
        tr = n; m_rs(ri, rc, rco); chk_outs("rs");
      end
      @(posedge clk); #1;
      if (tp >= 0) bus.pu_req = 0;
      if (tr >= 0) bus.rs_req = 0;
      n++;
    end
    bus.pu_req = 0; bus.rs_req = 0;
    if (do_pu) chk("pu_lat", tp, w_pu ? 3 : 7);
    if (do_rs) chk("rs_lat", tr, w_pu ? 7 : 3);
    m_last_pu = (do_pu && do_rs) ? !w_pu : do_pu;
  endtask
  task automatic mid_reset();
    logic seen;
    @(posedge clk); #1;
    bus.rs_req = 1; bus.rs_item = 1; bus.rs_count = 3; bus.rs_cost = 16'h99;
    repeat (3) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    hrst = 1; bus.rs_req = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.rs_done | bus.pu_done;
    end
    @(posedge clk); #1;
    hrst = 0;
    m_reset();
    chk("mid_no_done", seen, 0);
    @(negedge clk);
    chk("mid_idle", bus.busy, 0);
    chk_outs("mid");
    for (int i = 0; i < 7; i++) txn(0, 0, 0, 0, 1, 0, 3'(i));
  endtask
  initial begin
    bus.rs_req = 0; bus.rs_item = 0; bus.rs_count = 0; bus.rs_cost = 0;
    bus.pu_req = 0; bus.pu_op = 0; bus.pu_item = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 hrst = 0;
    @(negedge clk);
    chk("rst_done", {bus.rs_done, bus.pu_done, bus.busy}, 3'b000);
    chk_outs("rst");
    chk("rst_map", bus.empty_map, 7'h7f);
    txn(1, 0, 5, 16'h4B, 0, 0, 0);
    chk("tp1_rs_err", bus.rs_err, 0);
    txn(0, 0, 0, 0, 1, 0, 0);
    chk("tp1_cost", {bus.pu_avail, bus.pu_cost}, {1'b1, 16'h4B});
    chk("tp1_map0", bus.empty_map[0], 0);
    txn(1, 2, 10, 0, 0, 0, 0);
    txn(1, 2, 7, 0, 0, 0, 0);
    chk("ovf_err", bus.rs_err, 1);
    txn(1, 2, 6, 0, 0, 0, 0);
    chk("ovf_ok", bus.rs_err, 0);
    txn(0, 0, 0, 0, 1, 0, 2);
    txn(0, 0, 0, 0, 1, 1, 3);
    chk("empty_disp", {bus.pu_err, bus.pu_avail}, 2'b10);
    txn(1, 3, 1, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 1, 3);
    chk("disp1", {bus.pu_avail, bus.empty_map[3]}, 2'b11);
    txn(0, 0, 0, 0, 1, 1, 3);
    chk("disp2", bus.pu_err, 1);
    txn(1, 4, 2, 16'h10, 1, 0, 0);
    txn(1, 5, 3, 16'h20, 1, 1, 0);
    txn(0, 0, 0, 0, 1, 1, 7);
    chk("inv_pu", {bus.pu_err, bus.pu_avail, bus.pu_cost}, {2'b10, 16'h0});
    txn(1, 7, 4, 16'h55, 0, 0, 0);
    chk("inv_rs", bus.rs_err, 1);
    txn(1, 6, 0, 0, 0, 0, 0);
    chk("zero_rs", bus.rs_err, 0);
    mid_reset();
    for (int k = 0; k < 250; k++) begin
      int mode;
      mode = $urandom_range(1, 3);
      txn(mode[0], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 6)),
          ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0,
          mode[1], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 7; i++) txn(0, 0, 0, 0, 1, 0, 3'(i));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
